// File: rtl/pmem_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : lc3b_types
// Purpose : Shared types for the cache <-> physical-memory line interface and
//           the pmem_line_responder backing store.
//   lc3b_pmem_line     128-bit cache line
//   lc3b_pmem_addr     16-bit byte address on the pmem port
//   PMEM_OFFSET_BITS   byte-within-line offset bits (ignored by pmem)
//   pmem_resp_state_t  responder FSM encoding
// Revision: 1.0  initial release
// ============================================================================
package lc3b_types;

  typedef logic [127:0] lc3b_pmem_line;
  typedef logic [15:0]  lc3b_pmem_addr;

  localparam int PMEM_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_resp_state_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/pmem_line_array.sv
`default_nettype none
// ============================================================================
// Module  : pmem_line_array
// Purpose : LINES x 128-bit line storage with one synchronous write port and
//           one registered read port. Storage itself is never reset; only the
//           read-data register clears on rst.
// Ports   :
//   clk    in   clock
//   rst    in   asynchronous active-high reset (read register only)
//   we     in   write enable, commits wdata to waddr at the rising edge
//   waddr  in   write line index
//   wdata  in   write line data
//   re     in   read enable, loads rdata from raddr at the rising edge
//   raddr  in   read line index
//   rdata  out  registered read data, holds between reads
// Revision: 1.0  initial release
// ============================================================================
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int LINES = 32,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  lc3b_pmem_line    wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output lc3b_pmem_line    rdata
);

  lc3b_pmem_line mem [LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : pmem_line_array
`default_nettype wire

// File: rtl/pmem_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : pmem_line_responder
// Purpose : Physical-memory responder for the cache pmem_* line port. Accepts
//           one line read or write, answers LATENCY cycles after acceptance
//           with a one-cycle pmem_resp pulse, and stores LINES lines.
// Optional: PMEM_PROTOCOL_CHECK_EN builds a sticky protocol checker driving
//           pmem_err; without it pmem_err is tied low.
// Ports   :
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   pmem_read     in   line read request
//   pmem_write    in   line write request (wins when both are high)
//   pmem_address  in   byte address, bits [3:0] ignored, high bits alias
//   pmem_wdata    in   write line data
//   pmem_resp     out  one-cycle completion pulse
//   pmem_rdata    out  read data, valid with pmem_resp, held afterwards
//   pmem_err      out  sticky protocol-violation flag
// Revision: 1.0  initial release
// ============================================================================
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINES   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_pmem_addr pmem_address,
  input  lc3b_pmem_line pmem_wdata,
  output logic          pmem_resp,
  output lc3b_pmem_line pmem_rdata,
  output logic          pmem_err
);

  localparam int IDX_W = $clog2(LINES);
  // BUSY is entered one cycle after acceptance and RESP costs one more cycle.
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

  pmem_resp_state_t state;
  logic [7:0]       cnt;
  logic             op_write;
  logic [IDX_W-1:0] idx;
  lc3b_pmem_line    wdata_q;

  logic             req;
  logic [IDX_W-1:0] req_idx;
  logic             rd_load;
  logic             wr_commit;
  logic [IDX_W-1:0] rd_idx;

  assign req     = pmem_read | pmem_write;
  assign req_idx = pmem_address[PMEM_OFFSET_BITS +: IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      idx      <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= pmem_write;
            idx      <= req_idx;
            wdata_q  <= pmem_wdata;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_resp = (state == RESP);

  // The read register is loaded on the edge that enters RESP so the data is
  // presented together with pmem_resp. With LATENCY==1 that edge is the
  // acceptance edge itself, so the index comes straight from the port.
  assign rd_load   = ((state == IDLE) && req && !pmem_write && (LATENCY == 1)) ||
                     ((state == BUSY) && (cnt == 8'd0) && !op_write);
  assign rd_idx    = (state == IDLE) ? req_idx : idx;
  // Writes commit at the end of RESP; any later read enters RESP at least one
  // edge after this, so read-after-write sees the new line.
  assign wr_commit = (state == RESP) && op_write;

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_commit),
    .waddr (idx),
    .wdata (wdata_q),
    .re    (rd_load),
    .raddr (rd_idx),
    .rdata (pmem_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  lc3b_pmem_addr addr_q;
  logic          err_q;
  logic          violation;

  // Full address is kept so that offset-bit changes mid-transaction are also
  // caught, even though they do not affect the accessed line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if ((state == IDLE) && req) begin
      addr_q <= pmem_address;
    end
  end

  always_comb begin
    violation = 1'b0;
    case (state)
      IDLE: violation = pmem_read & pmem_write;
      BUSY, RESP: begin
        if (!req || (pmem_address != addr_q) || (pmem_write != op_write)) begin
          violation = 1'b1;
        end
        if ((state == BUSY) && op_write && (pmem_wdata != wdata_q)) begin
          violation = 1'b1;
        end
      end
      default: violation = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign pmem_err = err_q;
`else
  // Offset and alias bits only matter to the checker.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address;
  assign pmem_err         = 1'b0;
`endif

endmodule : pmem_line_responder
`default_nettype wire
